sliding_sum6: RTL and testbench

SLIDING_SUM6 -- requirements
Module: sliding_sum6

---
 rtl/sliding_sum6.sv | 72 +++++++
 tb/tb_sliding_sum6.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sliding_sum6.sv
// Sliding-window sum over the last DEPTH samples, with threshold hit flag.
// Optional peak tracker enabled by defining SLIDING_SUM6_PEAK_EN.
module sliding_sum6 #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 6,
  localparam int SUM_W = WIDTH + $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int EXT_W = SUM_W + 1
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [WIDTH-1:0] I,
  input  logic [WIDTH-1:0] D,
  input  logic             CLR,
  input  logic [SUM_W-1:0] THRESH,
  output logic [SUM_W-1:0] O,
  output logic             O_VALID,
  output logic             HIT
`ifdef SLIDING_SUM6_PEAK_EN
  ,
  output logic [SUM_W-1:0] PEAK
`endif
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             full;
  logic             valid_next;
  logic [SUM_W-1:0] sub;
  logic [SUM_W-1:0] sum_next;

  always_comb begin
    full = (cnt == CNT_W'(DEPTH));
    cnt_next = full ? cnt : cnt + CNT_W'(1);
    valid_next = (cnt_next == CNT_W'(DEPTH));
    // the delay line holds stale data until DEPTH fresh samples are in
    sub = full ? SUM_W'(D) : '0;
    sum_next = SUM_W'({1'b0, O} + EXT_W'(I) - {1'b0, sub});
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      cnt     <= '0;
      O       <= '0;
      O_VALID <= 1'b0;
      HIT     <= 1'b0;
    end else if (CLR) begin
      cnt     <= '0;
      O       <= '0;
      O_VALID <= 1'b0;
      HIT     <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      O       <= sum_next;
      O_VALID <= valid_next;
      HIT     <= valid_next && (sum_next >= THRESH);
    end
  end

`ifdef SLIDING_SUM6_PEAK_EN
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      PEAK <= '0;
    end else if (CLR) begin
      PEAK <= '0;
    end else if (valid_next && (sum_next > PEAK)) begin
      PEAK <= sum_next;
    end
  end
`endif

endmodule

// File: tb/tb_sliding_sum6.sv
// Directed vector bench for sliding_sum6; models the upstream delay line.
// Peak checks are compiled when SLIDING_SUM6_PEAK_EN is defined.
module tb_sliding_sum6;

  localparam int WIDTH = 4;
  localparam int DEPTH = 6;
  localparam int SUM_W = 7;

  logic             CLK;
  logic             ASYNCRESETN;
  logic [WIDTH-1:0] I;
  logic [WIDTH-1:0] D;
  logic             CLR;
  logic [SUM_W-1:0] THRESH;
  logic [SUM_W-1:0] O;
  logic             O_VALID;
  logic             HIT;
`ifdef SLIDING_SUM6_PEAK_EN
  logic [SUM_W-1:0] PEAK;
`endif

  sliding_sum6 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .I(I),
    .D(D),
    .CLR(CLR),
    .THRESH(THRESH),
    .O(O),
    .O_VALID(O_VALID),
    .HIT(HIT)
`ifdef SLIDING_SUM6_PEAK_EN
    ,
    .PEAK(PEAK)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // upstream delay line, never reset
  logic [WIDTH-1:0] dl [DEPTH];
  always @(posedge CLK) begin
    dl[0] <= I;
    for (int j = 1; j < DEPTH; j++) dl[j] <= dl[j-1];
  end
  assign D = dl[DEPTH-1];

  typedef struct {
    logic [WIDTH-1:0] i;
    logic             clr;
    logic [SUM_W-1:0] th;
    logic [SUM_W-1:0] o;
    logic             v;
    logic             h;
  } vec_t;

  vec_t vecs[$];
  int passed = 0;
  int total  = 0;

  function automatic void add(int i, int clr, int th, int o, int v, int h);
    vec_t t;
    t.i = WIDTH'(i);
    t.clr = clr[0];
    t.th = SUM_W'(th);
    t.o = SUM_W'(o);
    t.v = v[0];
    t.h = h[0];
    vecs.push_back(t);
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive_step(int i, int clr, int th);
    I = WIDTH'(i);
    CLR = clr[0];
    THRESH = SUM_W'(th);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    ASYNCRESETN = 1'b0;
    I = '0;
    CLR = 1'b0;
    THRESH = '0;

    // fill, threshold 0 so HIT tracks O_VALID
    add(1,0,0, 1,0,0); add(1,0,0, 2,0,0); add(1,0,0, 3,0,0);
    add(1,0,0, 4,0,0); add(1,0,0, 5,0,0); add(1,0,0, 6,1,1);
    add(1,0,0, 6,1,1); add(1,0,0, 6,1,1);
    add(0,1,0, 0,0,0);
    // slide max values, threshold exactly at the peak
    add(15,0,90, 15,0,0); add(15,0,90, 30,0,0); add(15,0,90, 45,0,0);
    add(15,0,90, 60,0,0); add(15,0,90, 75,0,0); add(15,0,90, 90,1,1);
    add(0,0,90, 75,1,0); add(0,0,90, 60,1,0); add(0,0,90, 45,1,0);
    add(0,0,90, 30,1,0); add(0,0,90, 15,1,0); add(0,0,90, 0,1,0);
    add(0,0,90, 0,1,0);
    // load delay line with 15s, then clear and refill with 2s
    add(15,0,0, 15,1,1); add(15,0,0, 30,1,1); add(15,0,0, 45,1,1);
    add(15,0,0, 60,1,1); add(15,0,0, 75,1,1); add(15,0,0, 90,1,1);
    add(15,0,0, 90,1,1); add(15,0,0, 90,1,1); add(15,0,0, 90,1,1);
    add(15,0,0, 90,1,1);
    add(15,1,0, 0,0,0);
    add(2,0,0, 2,0,0); add(2,0,0, 4,0,0); add(2,0,0, 6,0,0);
    add(2,0,0, 8,0,0); add(2,0,0, 10,0,0); add(2,0,0, 12,1,1);
    add(2,0,0, 12,1,1); add(2,0,0, 12,1,1);
    // threshold 30 with I=5
    add(0,1,30, 0,0,0);
    add(5,0,30, 5,0,0); add(5,0,30, 10,0,0); add(5,0,30, 15,0,0);
    add(5,0,30, 20,0,0); add(5,0,30, 25,0,0); add(5,0,30, 30,1,1);
    add(5,0,30, 30,1,1); add(5,0,30, 30,1,1);
    // CLR held two cycles, then threshold 31 never hit
    add(5,1,31, 0,0,0); add(5,1,31, 0,0,0);
    add(5,0,31, 5,0,0); add(5,0,31, 10,0,0); add(5,0,31, 15,0,0);
    add(5,0,31, 20,0,0); add(5,0,31, 25,0,0); add(5,0,31, 30,1,0);
    add(5,0,31, 30,1,0); add(5,0,31, 30,1,0);

    repeat (2) @(negedge CLK);
    check("reset_o", int'(O), 0);
    check("reset_valid", int'(O_VALID), 0);
    check("reset_hit", int'(HIT), 0);
`ifdef SLIDING_SUM6_PEAK_EN
    check("reset_peak", int'(PEAK), 0);
`endif
    ASYNCRESETN = 1'b1;

    foreach (vecs[n]) begin
      drive_step(int'(vecs[n].i), int'(vecs[n].clr), int'(vecs[n].th));
      if (O !== vecs[n].o)
        check($sformatf("vec%0d_o", n), int'(O), int'(vecs[n].o));
      else check($sformatf("vec%0d_o", n), int'(O), int'(vecs[n].o));
      check($sformatf("vec%0d_valid", n), int'(O_VALID), int'(vecs[n].v));
      check($sformatf("vec%0d_hit", n), int'(HIT), int'(vecs[n].h));
    end

    // asynchronous reset in the middle of a window
    drive_step(0, 1, 0);
    repeat (4) drive_step(10, 0, 0);
    check("pre_reset_o", int'(O), 40);
    ASYNCRESETN = 1'b0;
    #1;
    check("async_o", int'(O), 0);
    check("async_valid", int'(O_VALID), 0);
    check("async_hit", int'(HIT), 0);
    @(posedge CLK);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    check("held_reset_o", int'(O), 0);
    for (int k = 0; k < 8; k++) begin
      drive_step(1, 0, 0);
      check($sformatf("refill%0d_o", k), int'(O), (k < 6) ? k + 1 : 6);
      check($sformatf("refill%0d_valid", k), int'(O_VALID), (k >= 5) ? 1 : 0);
      check($sformatf("refill%0d_hit", k), int'(HIT), (k >= 5) ? 1 : 0);
    end

`ifdef SLIDING_SUM6_PEAK_EN
    drive_step(0, 1, 0);
    check("peak_clr0", int'(PEAK), 0);
    for (int k = 0; k < 6; k++) begin
      drive_step(9, 0, 0);
      check($sformatf("peak_up%0d_o", k), int'(O), 9 * (k + 1));
      check($sformatf("peak_up%0d", k), int'(PEAK), (k == 5) ? 54 : 0);
    end
    for (int k = 0; k < 6; k++) begin
      drive_step(0, 0, 0);
      check($sformatf("peak_dn%0d_o", k), int'(O), 54 - 9 * (k + 1));
      check($sformatf("peak_dn%0d", k), int'(PEAK), 54);
    end
    drive_step(0, 1, 0);
    check("peak_clr1", int'(PEAK), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
